// File: rtl/mem_responder.sv
// mem_responder: fixed-latency 16-bit word memory responder with an IDLE/BUSY/DONE handshake.
// Define MEM_RESP_ALIGN_CHECK_EN to reject requests whose Addr[0] is set.
module mem_responder #(
  parameter int LATENCY = 4,
  parameter int MEM_AW  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] Data_in,
  output logic [15:0] Data_out,
  output logic        Stall,
  output logic        Done,
  output logic        Err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [MEM_AW-1:0] idx;
  logic [15:0] wdata;
  logic is_wr, err_q, open_st, misaligned, req_ok, req_bad;
  logic [15:0] mem [2**MEM_AW];
  logic unused_bits;
`ifdef MEM_RESP_ALIGN_CHECK_EN
  assign misaligned = Addr[0];
`else
  assign misaligned = 1'b0;
`endif
  assign unused_bits = ^{Addr[15:MEM_AW+1], Addr[0]};
  assign open_st = state != BUSY;
  assign req_ok  = open_st && (Rd ^ Wr) && !misaligned;
  assign req_bad = open_st && ((Rd && Wr) || (misaligned && (Rd || Wr)));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      wdata <= '0;
      is_wr <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= req_bad;
      if (req_ok) begin
        cnt   <= 4'(LATENCY - 1);
        idx   <= Addr[MEM_AW:1];
        wdata <= Data_in;
        is_wr <= Wr;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end
    end
  end
  // The write lands on the edge leaving DONE, so a reset while BUSY or DONE drops it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**MEM_AW; i++) mem[i] <= '0;
    end else if (state == DONE && is_wr) begin
      mem[idx] <= wdata;
    end
  end
  // BUSY lasts LATENCY-1 cycles, so LATENCY=1 skips it and goes straight to DONE.
  always_comb begin
    state_nx = state == BUSY ? (cnt == 4'd1 ? DONE : BUSY)
             : req_ok ? (LATENCY == 1 ? DONE : BUSY) : IDLE;
  end
  always_comb begin
    Stall    = state == BUSY;
    Done     = state == DONE;
    Err      = err_q;
    Data_out = (state == DONE && !is_wr) ? mem[idx] : '0;
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: transaction-level model plus directed checks for mem_responder (LATENCY 4 and 1).
module tb_mem_responder;
  localparam int LAT = 4;
`ifdef MEM_RESP_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic rd, wr, rd1, wr1;
  logic [15:0] addr, din, addr1, din1;
  logic [15:0] Data_out, Data_out1;
  logic Stall, Done, Err, Stall1, Done1, Err1;
  int total = 0, bad = 0;
  bit stall1_seen = 1'b0;
  mem_responder #(.LATENCY(LAT), .MEM_AW(8)) dut (
    .clk(clk), .rst(rst), .Rd(rd), .Wr(wr), .Addr(addr), .Data_in(din),
    .Data_out(Data_out), .Stall(Stall), .Done(Done), .Err(Err));
  mem_responder #(.LATENCY(1), .MEM_AW(8)) dut1 (
    .clk(clk), .rst(rst), .Rd(rd1), .Wr(wr1), .Addr(addr1), .Data_in(din1),
    .Data_out(Data_out1), .Stall(Stall1), .Done(Done1), .Err(Err1));
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  // Model: m_t counts cycles since acceptance; the transaction is done when m_t reaches LAT.
  bit m_act = 1'b0, m_wr = 1'b0, m_err = 1'b0, m_bad;
  int m_t = 0;
  logic [7:0] m_idx = '0;
  logic [15:0] m_din = '0;
  logic [15:0] m_mem [256];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act = 1'b0;
      m_t   = 0;
      m_err = 1'b0;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (m_act && m_t < LAT) begin
      m_t++;
      m_err = 1'b0;
    end else begin
      if (m_act && m_wr) m_mem[m_idx] = m_din;
      m_bad = (rd && wr) || (ALIGN && addr[0] && (rd || wr));
      m_err = m_bad;
      m_act = (rd ^ wr) && !m_bad;
      m_t   = 1;
      m_wr  = wr;
      m_idx = addr[8:1];
      m_din = din;
    end
  end
  always @(negedge clk) begin
    chk("stall", {15'd0, Stall}, {15'd0, m_act && m_t < LAT});
    chk("done", {15'd0, Done}, {15'd0, m_act && m_t == LAT});
    chk("err", {15'd0, Err}, {15'd0, m_err});
    chk("data", Data_out, (m_act && m_t == LAT && !m_wr) ? m_mem[m_idx] : 16'h0);
    if (Stall1) stall1_seen = 1'b1;
  end

  task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    rd = r; wr = w; addr = a; din = d;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, input logic [15:0] exp_d, input string n);
    int c = 1;
    while (!Done && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk({n, "_lat"}, 16'(c), 16'(exp_lat));
    chk(n, Data_out, exp_d);
  endtask

  initial begin
    rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", {15'd0, Stall}, 16'd0);
    chk("rst_data", Data_out, 16'd0);
    rst = 1'b1; rd1 = 1'b1; addr1 = 16'h0000;
    @(negedge clk);
    rd1 = 1'b0;
    chk("lat1_done", {15'd0, Done1}, 16'd1);
    chk("lat1_data", Data_out1, 16'h0000);
    chk("lat1_err", {15'd0, Err1}, 16'd0);
    drive(1'b1, 1'b1, 16'h0010, 16'h0);
    chk("rej_err", {15'd0, Err}, 16'd1);
    chk("rej_stall", {15'd0, Stall}, 16'd0);
    chk("rej_done", {15'd0, Done}, 16'd0);
    @(negedge clk);
    chk("rej_one_cycle", {15'd0, Err}, 16'd0);
    drive(1'b1, 1'b0, 16'h0010, 16'h0);
    wait_done(4, 16'h0000, "rd_after_rej");
    drive(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("wr_stall1", {15'd0, Stall}, 16'd1);
    @(negedge clk);
    chk("wr_stall2", {15'd0, Stall}, 16'd1);
    @(negedge clk);
    chk("wr_stall3", {15'd0, Stall}, 16'd1);
    @(negedge clk);
    chk("wr_done4", {15'd0, Done}, 16'd1);
    chk("wr_done_data", Data_out, 16'h0000);
    drive(1'b1, 1'b0, 16'h0010, 16'h0);
    wait_done(4, 16'hBEEF, "rd_beef");
    drive(1'b0, 1'b1, 16'h0002, 16'h1234);
    #2 rst = 1'b0;
    #1;
    chk("async_stall", {15'd0, Stall}, 16'd0);
    chk("async_done", {15'd0, Done}, 16'd0);
    chk("async_err", {15'd0, Err}, 16'd0);
    chk("async_data", Data_out, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h0002, 16'h0);
    wait_done(4, 16'h0000, "rd_aborted_wr");
    drive(1'b1, 1'b0, 16'h0010, 16'h0);
    wait_done(4, 16'h0000, "rd_cleared");
    drive(1'b0, 1'b1, 16'h0020, 16'hA5A5);
    repeat (3) @(negedge clk);
    chk("b2b_done", {15'd0, Done}, 16'd1);
    rd = 1'b1; addr = 16'h0020;
    @(negedge clk);
    rd = 1'b0;
    chk("b2b_no_idle", {15'd0, Stall}, 16'd1);
    wait_done(4, 16'hA5A5, "b2b_rd");
    drive(1'b0, 1'b1, 16'h0002, 16'h7777);
    wait_done(4, 16'h0000, "wr_7777");
    drive(1'b1, 1'b0, 16'h0003, 16'h0);
`ifdef MEM_RESP_ALIGN_CHECK_EN
    chk("odd_err", {15'd0, Err}, 16'd1);
    repeat (4) @(negedge clk);
    chk("odd_no_done", {15'd0, Done}, 16'd0);
`else
    wait_done(4, 16'h7777, "odd_rd");
`endif
    drive(1'b0, 1'b1, 16'h0240, 16'h1111);
    wait_done(4, 16'h0000, "wr_wrap");
    drive(1'b1, 1'b0, 16'h0040, 16'h0);
    wait_done(4, 16'h1111, "rd_wrap");
    drive(1'b0, 1'b1, 16'h0030, 16'h3333);
    repeat (3) @(negedge clk);
    rd = 1'b1; wr = 1'b1;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    chk("done_rej_err", {15'd0, Err}, 16'd1);
    chk("done_rej_idle", {15'd0, Stall}, 16'd0);
    drive(1'b1, 1'b0, 16'h0030, 16'h0);
    wait_done(4, 16'h3333, "rej_keeps_wr");
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      rd = (i % 3) == 0; wr = (i % 5) == 0;
      addr = 16'(i * 6); din = 16'(i * 16'h1111);
    end
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    repeat (6) @(negedge clk);
    wr1 = 1'b1; addr1 = 16'h0004; din1 = 16'h55AA;
    @(negedge clk);
    wr1 = 1'b0;
    chk("lat1_wr_done", {15'd0, Done1}, 16'd1);
    rd1 = 1'b1;
    @(negedge clk);
    rd1 = 1'b0;
    chk("lat1_b2b_done", {15'd0, Done1}, 16'd1);
    chk("lat1_b2b_data", Data_out1, 16'h55AA);
    chk("lat1_no_stall", {15'd0, stall1_seen}, 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
